// File: rtl/keypad_scanner.sv
// keypad_scanner: matrix keypad scanner with per-key debounce and
// press/release events over a valid/ready handshake.
//
// Optional feature macro: KEYPAD_AUTOREPEAT_EN
//   Defined   -> a single held key re-reports as a press after
//                REPEAT_DELAY_SCANS full scans, then every REPEAT_RATE_SCANS.
//   Undefined -> exactly one press and one release per debounced transition.
//
// Event handshake: evt_valid/evt_code/evt_press form one registered event.
// Once evt_valid is high, code and press stay stable until a rising edge
// sees evt_valid && evt_ready. A new event may load on that same edge.
// While an event waits unaccepted, the scan holds in EMIT, so no event is
// ever dropped or overwritten.

module keypad_scanner #(
   parameter int ROWS           = 4,
   parameter int COLS           = 4,
   parameter int SETTLE_CYCLES  = 512,
   parameter int DEBOUNCE_SCANS = 3,
`ifdef KEYPAD_AUTOREPEAT_EN
   parameter int REPEAT_DELAY_SCANS = 64,
   parameter int REPEAT_RATE_SCANS  = 16,
`endif
   localparam int KW = $clog2(ROWS*COLS)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [COLS-1:0]      cols,
   output logic [ROWS-1:0]      rows,
   output logic                 evt_valid,
   input  logic                 evt_ready,
   output logic [KW-1:0]        evt_code,
   output logic                 evt_press,
   output logic                 key_pressed,
   output logic [ROWS*COLS-1:0] key_map
);

   localparam int NK = ROWS*COLS;
   localparam int RW = $clog2(ROWS);
   localparam int CW = $clog2(COLS);
   localparam int SW = $clog2(SETTLE_CYCLES);
   localparam logic [3:0] DB_TARGET = 4'(DEBOUNCE_SCANS);

   typedef enum logic [1:0] {
      S_DRIVE  = 2'd0,
      S_SAMPLE = 2'd1,
      S_EMIT   = 2'd2,
      S_NEXT   = 2'd3
   } state_t;

   state_t            state;
   logic [RW-1:0]     row_idx;
   logic [RW-1:0]     row_nxt;
   logic [SW-1:0]     settle_cnt;
   logic [COLS-1:0]   pending;
   logic [3:0]        db_cnt [NK];

   logic [1:0]        rst_pipe;
   logic              rst_core_n;
   logic [COLS-1:0]   cols_meta;
   logic [COLS-1:0]   cols_sync;

   logic [KW-1:0]     key_base;
   logic [KW-1:0]     samp_key [COLS];
   logic [COLS-1:0]   samp_diff;
   logic [COLS-1:0]   samp_flip;

   logic              have_flip;
   logic [CW-1:0]     take_col;
   logic [KW-1:0]     take_key;
   logic              take_ok;
   logic              take;
   logic [NK-1:0]     key_map_nxt;

`ifdef KEYPAD_AUTOREPEAT_EN
   logic              single;
   logic [KW-1:0]     single_code;
   logic              scan_end;
   logic              rep_take;
   logic [15:0]       rep_cnt;
   logic              rep_armed;
   logic              rep_pend;
`endif

   // Reset: asserts immediately, releases two clocks after rst_n rises.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) rst_pipe <= 2'b00;
      else        rst_pipe <= {rst_pipe[0], 1'b1};
   end

   assign rst_core_n = rst_pipe[1];

   // Two-stage synchroniser for the asynchronous column pins (idle = high).
   always_ff @(posedge clk or negedge rst_core_n) begin
      if (!rst_core_n) begin
         cols_meta <= '1;
         cols_sync <= '1;
      end else begin
         cols_meta <= cols;
         cols_sync <= cols_meta;
      end
   end

   // Per-column sample decode: key index, raw-vs-debounced difference, flip.
   always_comb begin
      key_base  = KW'(int'(row_idx) * COLS);
      samp_key  = '{default: '0};
      samp_diff = '0;
      samp_flip = '0;
      for (int c = 0; c < COLS; c++) begin
         samp_key[c]  = key_base + KW'(c);
         samp_diff[c] = (~cols_sync[c]) ^ key_map[samp_key[c]];
         samp_flip[c] = samp_diff[c] && ((db_cnt[samp_key[c]] + 4'd1) == DB_TARGET);
      end
   end

   // Lowest pending column wins; a flip is only taken when the event slot is free.
   always_comb begin
      have_flip = 1'b0;
      take_col  = '0;
      for (int c = COLS-1; c >= 0; c--) begin
         if (pending[c]) begin
            have_flip = 1'b1;
            take_col  = CW'(c);
         end
      end
      take_ok     = (state == S_EMIT) && !(evt_valid && !evt_ready);
      take        = take_ok && have_flip;
      take_key    = key_base + KW'(take_col);
      key_map_nxt = key_map;
      if (take) key_map_nxt[take_key] = ~key_map[take_key];
      row_nxt     = (row_idx == RW'(ROWS-1)) ? '0 : row_idx + RW'(1);
   end

`ifdef KEYPAD_AUTOREPEAT_EN
   // Single-key detection and its code, used for autorepeat.
   always_comb begin
      single      = (key_map != '0) && ((key_map & (key_map - NK'(1))) == '0);
      single_code = '0;
      for (int i = 0; i < NK; i++) begin
         if (key_map[i]) single_code = KW'(i);
      end
      scan_end = (state == S_NEXT) && (row_idx == RW'(ROWS-1));
      rep_take = take_ok && !have_flip && rep_pend;
   end

   // Repeat timer: counts full scans while exactly one key is held.
   always_ff @(posedge clk or negedge rst_core_n) begin
      if (!rst_core_n) begin
         rep_cnt   <= '0;
         rep_armed <= 1'b0;
         rep_pend  <= 1'b0;
      end else if (!single || take) begin
         rep_cnt   <= '0;
         rep_armed <= 1'b0;
         rep_pend  <= 1'b0;
      end else begin
         if (rep_take) rep_pend <= 1'b0;
         if (scan_end) begin
            if ((rep_cnt + 16'd1) == (rep_armed ? 16'(REPEAT_RATE_SCANS)
                                                : 16'(REPEAT_DELAY_SCANS))) begin
               rep_cnt   <= '0;
               rep_armed <= 1'b1;
               rep_pend  <= 1'b1;
            end else begin
               rep_cnt <= rep_cnt + 16'd1;
            end
         end
      end
   end
`endif

   // Debounce counters: count consecutive differing scans, clear on agreement or flip.
   always_ff @(posedge clk or negedge rst_core_n) begin
      if (!rst_core_n) begin
         for (int i = 0; i < NK; i++) db_cnt[i] <= '0;
      end else if (state == S_SAMPLE) begin
         for (int c = 0; c < COLS; c++) begin
            if (samp_diff[c] && !samp_flip[c])
               db_cnt[samp_key[c]] <= db_cnt[samp_key[c]] + 4'd1;
            else
               db_cnt[samp_key[c]] <= '0;
         end
      end
   end

   // Debounced map and any-key level, updated in the cycle a flip is taken.
   always_ff @(posedge clk or negedge rst_core_n) begin
      if (!rst_core_n) begin
         key_map     <= '0;
         key_pressed <= 1'b0;
      end else begin
         key_map     <= key_map_nxt;
         key_pressed <= |key_map_nxt;
      end
   end

   // Scan FSM with registered row drive and event register.
   always_ff @(posedge clk or negedge rst_core_n) begin
      if (!rst_core_n) begin
         state      <= S_DRIVE;
         row_idx    <= '0;
         settle_cnt <= '0;
         rows       <= '1;
         pending    <= '0;
         evt_valid  <= 1'b0;
         evt_code   <= '0;
         evt_press  <= 1'b0;
      end else begin
         if (evt_valid && evt_ready) evt_valid <= 1'b0;
         case (state)
            S_DRIVE: begin
               rows <= ~(ROWS'(1) << row_idx);
               if (settle_cnt == SW'(SETTLE_CYCLES-1)) begin
                  settle_cnt <= '0;
                  state      <= S_SAMPLE;
               end else begin
                  settle_cnt <= settle_cnt + SW'(1);
               end
            end
            S_SAMPLE: begin
               pending <= samp_flip;
               state   <= S_EMIT;
            end
            S_EMIT: begin
               if (take) begin
                  evt_valid         <= 1'b1;
                  evt_code          <= take_key;
                  evt_press         <= ~key_map[take_key];
                  pending[take_col] <= 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
               end else if (rep_take) begin
                  evt_valid <= 1'b1;
                  evt_code  <= single_code;
                  evt_press <= 1'b1;
`endif
               end else if (take_ok) begin
                  state <= S_NEXT;
               end
            end
            S_NEXT: begin
               row_idx <= row_nxt;
               rows    <= ~(ROWS'(1) << row_nxt);
               state   <= S_DRIVE;
            end
            default: state <= S_DRIVE;
         endcase
      end
   end

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: randomized bench for keypad_scanner with a keypad
// matrix model and an event scoreboard driven by the debounced-key rules.

module tb_keypad_scanner;

   localparam int ROWS   = 4;
   localparam int COLS   = 4;
   localparam int SETTLE = 8;
   localparam int DB     = 3;
   localparam int NK     = ROWS*COLS;
   localparam int KW     = 4;
   localparam int LAT_BOUND = (DB+1)*ROWS*(SETTLE+2+COLS)+3;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic [COLS-1:0] cols;
   logic [ROWS-1:0] rows;
   logic            evt_valid;
   logic            evt_ready = 1'b0;
   logic [KW-1:0]   evt_code;
   logic            evt_press;
   logic            key_pressed;
   logic [NK-1:0]   key_map;

   logic [NK-1:0]   phys = '0;
   logic [NK-1:0]   model_map = '0;
   logic [KW:0]     exp_q[$];
   logic [KW:0]     mon_e;
   int              checks = 0;
   int              failures = 0;
   bit              rand_ready_en = 1'b0;

   keypad_scanner #(
      .ROWS(ROWS), .COLS(COLS), .SETTLE_CYCLES(SETTLE), .DEBOUNCE_SCANS(DB)
   ) dut (
      .clk(clk), .rst_n(rst_n), .cols(cols), .rows(rows),
      .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_code(evt_code),
      .evt_press(evt_press), .key_pressed(key_pressed), .key_map(key_map)
   );

   // clock
   always #5 clk = ~clk;

   // keypad matrix: a held key pulls its column low while its row is driven low
   always_comb begin
      cols = '1;
      for (int r = 0; r < ROWS; r++)
         for (int c = 0; c < COLS; c++)
            if (!rows[r] && phys[r*COLS+c]) cols[c] = 1'b0;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // scoreboard: every accepted event must match the head of the expected queue
   always @(negedge clk) begin
      if (rst_n && evt_valid && evt_ready) begin
         check("evt_q_nonempty", 32'(exp_q.size() > 0), 32'd1);
         if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            check("evt_code", 32'(evt_code), 32'(mon_e[KW:1]));
            check("evt_press", 32'(evt_press), 32'(mon_e[0]));
         end
         check("map_matches_evt", 32'(key_map[evt_code]), 32'(evt_press));
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
      if (rand_ready_en) evt_ready = ($urandom_range(0, 3) != 0);
   endtask

   task automatic wait_scan_start();
      logic [ROWS-1:0] prev;
      bit found = 1'b0;
      for (int i = 0; i < 3000 && !found; i++) begin
         prev = rows;
         step();
         if (prev != 4'b1110 && rows == 4'b1110) found = 1'b1;
      end
      check("scan_start", 32'(found), 32'd1);
   endtask

   task automatic wait_scans(input int n);
      for (int i = 0; i < n; i++) wait_scan_start();
   endtask

   // apply a lasting key change at a scan start; debounced events follow in row-major order
   task automatic apply_keys(input logic [NK-1:0] nk);
      wait_scan_start();
      phys = nk;
      for (int k = 0; k < NK; k++)
         if (nk[k] != model_map[k]) exp_q.push_back({KW'(k), nk[k]});
      model_map = nk;
   endtask

   // change keys for fewer scans than the debounce depth, then restore
   task automatic glitch_keys(input logic [NK-1:0] gk, input int n_scans);
      logic [NK-1:0] keep;
      keep = phys;
      wait_scan_start();
      phys = gk;
      wait_scans(n_scans);
      phys = keep;
      wait_scans(2);
   endtask

   initial begin
      logic [ROWS-1:0] prev_r;
      logic [ROWS-1:0] exp_rows;
      logic [NK-1:0]   m;
      int              exp_row;
      int              lat;
      bit              seen;
      bit              any_valid;

      // reset
      rst_n = 1'b0;
      repeat (3) step();
      check("rst_rows", 32'(rows), 32'hF);
      check("rst_valid", 32'(evt_valid), 32'd0);
      check("rst_code", 32'(evt_code), 32'd0);
      check("rst_map", 32'(key_map), 32'd0);
      check("rst_pressed", 32'(key_pressed), 32'd0);
      rst_n = 1'b1;
      evt_ready = 1'b1;

      // idle scans: rows walk one-low 1110,1101,1011,0111 and no events
      prev_r = rows;
      exp_row = 0;
      any_valid = 1'b0;
      for (int i = 0; i < 10*ROWS*(SETTLE+3)+20; i++) begin
         step();
         if (evt_valid) any_valid = 1'b1;
         if (rows != prev_r) begin
            exp_rows = ~(4'b0001 << exp_row);
            check("rows_seq", 32'(rows), 32'(exp_rows));
            exp_row = (exp_row + 1) % ROWS;
            prev_r = rows;
         end
      end
      check("idle_no_valid", 32'(any_valid), 32'd0);
      check("idle_map", 32'(key_map), 32'd0);

      // single key row 1 col 2 -> code 6, with latency bound
      apply_keys(16'h0040);
      lat = 0;
      seen = 1'b0;
      while (!seen && lat < LAT_BOUND + 20) begin
         step();
         lat++;
         if (evt_valid) seen = 1'b1;
      end
      check("press_seen", 32'(seen), 32'd1);
      check("press_latency_ok", 32'(lat <= LAT_BOUND), 32'd1);
      wait_scans(5);
      check("k6_map", 32'(key_map), 32'h0040);
      check("k6_pressed", 32'(key_pressed), 32'd1);
      apply_keys(16'h0000);
      wait_scans(5);
      check("k6_rel_map", 32'(key_map), 32'd0);
      check("k6_rel_pressed", 32'(key_pressed), 32'd0);

      // short pulse on key (2,0) produces nothing
      glitch_keys(16'h0100, 2);
      wait_scans(3);
      check("glitch_map", 32'(key_map), 32'd0);

      // keys 0 and 15 under backpressure: nothing lost
      apply_keys(16'h8001);
      evt_ready = 1'b0;
      repeat (5000) step();
      check("stall_valid", 32'(evt_valid), 32'd1);
      check("stall_code", 32'(evt_code), 32'd0);
      check("stall_press", 32'(evt_press), 32'd1);
      evt_ready = 1'b1;
      wait_scans(5);
      check("stall_map", 32'(key_map), 32'h8001);
      apply_keys(16'h0000);
      wait_scans(5);

      // randomized key changes and glitches with random backpressure
      rand_ready_en = 1'b1;
      for (int it = 0; it < 14; it++) begin
         m = '0;
         repeat ($urandom_range(1, 3)) m[$urandom_range(0, NK-1)] = 1'b1;
         if ($urandom_range(0, 3) == 0) begin
            glitch_keys(phys ^ m, $urandom_range(1, 2));
         end else begin
            apply_keys(phys ^ m);
            wait_scans(5);
            check("rand_map", 32'(key_map), 32'(model_map));
            check("rand_pressed", 32'(key_pressed), 32'(model_map != '0));
         end
      end
      rand_ready_en = 1'b0;
      evt_ready = 1'b1;
      apply_keys(16'h0000);
      wait_scans(5);
      check("rand_release_map", 32'(key_map), 32'd0);

      // reset while an event is pending
      evt_ready = 1'b0;
      apply_keys(16'h0020);
      seen = 1'b0;
      for (int i = 0; i < LAT_BOUND + 20 && !seen; i++) begin
         step();
         if (evt_valid) seen = 1'b1;
      end
      check("pend_seen", 32'(seen), 32'd1);
      #3;
      rst_n = 1'b0;
      #1;
      check("async_rst_valid", 32'(evt_valid), 32'd0);
      check("async_rst_rows", 32'(rows), 32'hF);
      check("async_rst_map", 32'(key_map), 32'd0);
      exp_q.delete();
      model_map = '0;
      repeat (3) step();
      rst_n = 1'b1;
      exp_q.push_back({KW'(5), 1'b1});
      model_map = 16'h0020;
      evt_ready = 1'b1;
      wait_scans(6);
      check("rereport_map", 32'(key_map), 32'h0020);
      apply_keys(16'h0000);
      wait_scans(5);
      check("final_map", 32'(key_map), 32'd0);
      check("exp_q_drained", 32'(exp_q.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
